// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared widths and types for the ram_4096 request front-end.
//   DATA_W / ADDR_W : fixed by the ram_4096 data and address ports.
//   addr_t, data_t  : RAM address and data words.
//   wr_req_t        : one buffered write (address + data).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package ram_ctrl_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wr_req_t;

endpackage : ram_ctrl_pkg

// File: rtl/ram_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// ram_ctrl_fifo
// Parameterised synchronous FIFO built from registers.
//   clk, resetn    : clock, asynchronous active-low reset
//   push_i, din_i  : write side (ignored while full)
//   pop_i          : read side (ignored while empty)
//   dout_o         : head entry, all-zero while empty
//   empty_o/full_o : status flags
//   count_o        : occupancy, 0..DEPTH
//   entries_o      : raw storage, for callers that search the contents
//   entry_valid_o  : which storage slots currently hold live entries
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ram_ctrl_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  T                       din_i,
    input  logic                   pop_i,
    output T                       dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output T                       entries_o [DEPTH],
    output logic [DEPTH-1:0]       entry_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head output and per-slot liveness (slot is live if it lies within count of the read pointer).
    always_comb begin
        if (empty_o) begin
            dout_o = '0;
        end else begin
            dout_o = mem_q[rd_ptr_q];
        end
        for (int i = 0; i < DEPTH; i++) begin
            entries_o[i]     = mem_q[i];
            entry_valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : ram_ctrl_fifo

// File: rtl/ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// ram_req_ctrl
// Request front-end driving every port of the ram_4096 dual-port RAM.
//   clk, resetn                          : shared clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data    : write requests, buffered in a FIFO
//   rd_valid/rd_ready/rd_addr            : read requests, issued straight to RAM
//   rsp_valid/rsp_ready/rsp_data         : read responses, in request order
//   ram_write/ram_wr_address/ram_data_in : RAM write port
//   ram_read/ram_rd_address              : RAM read port
//   ram_data_out                         : RAM read data (one cycle after ram_read)
//   wfifo_count                          : write-buffer occupancy
// Reads are held off while their address is still sitting in the write
// buffer, so a read always observes every earlier accepted write.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  addr_t                        wr_addr,
    input  data_t                        wr_data,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  addr_t                        rd_addr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output data_t                        rsp_data,
    output logic                         ram_write,
    output addr_t                        ram_wr_address,
    output data_t                        ram_data_in,
    output logic                         ram_read,
    output addr_t                        ram_rd_address,
    input  data_t                        ram_data_out,
    output logic [$clog2(WFIFO_DEPTH):0] wfifo_count
);

    localparam int RC_W = $clog2(RSP_DEPTH) + 1;
    localparam int CU_W = RC_W + 1;

    // live_q holds all RAM strobes off for the first cycle after reset release.
    logic                   live_q;
    logic                   live_d;
    logic                   inflight_q;
    logic                   inflight_d;

    wr_req_t                wfifo_din_s;
    wr_req_t                wfifo_head_s;
    wr_req_t                wfifo_entries_s [WFIFO_DEPTH];
    logic [WFIFO_DEPTH-1:0] wfifo_valid_s;
    logic                   wfifo_empty_s;
    logic                   wfifo_full_s;
    logic                   wfifo_push_s;
    logic                   wfifo_pop_s;

    logic                   rsp_empty_s;
    logic                   rsp_pop_s;
    logic [RC_W-1:0]        rsp_count_s;
    logic                   rsp_full_unused_s;
    data_t                  rsp_entries_unused_s [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]   rsp_valid_unused_s;

    logic                   addr_hit_s;
    logic [CU_W-1:0]        credit_used_s;
    logic                   credit_ok_s;
    logic                   rd_fire_s;

    // Write path: accept into the buffer, drain one head entry per cycle to the RAM.
    always_comb begin
        wr_ready         = !wfifo_full_s;
        wfifo_push_s     = wr_valid && !wfifo_full_s;
        wfifo_din_s.addr = wr_addr;
        wfifo_din_s.data = wr_data;
        wfifo_pop_s      = live_q && !wfifo_empty_s;
        ram_write        = wfifo_pop_s;
        ram_wr_address   = wfifo_head_s.addr;
        ram_data_in      = wfifo_head_s.data;
    end

    // Read-after-write hazard: any live buffered write, including the head being issued now.
    always_comb begin
        addr_hit_s = 1'b0;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            if (wfifo_valid_s[i] && (wfifo_entries_s[i].addr == rd_addr)) begin
                addr_hit_s = 1'b1;
            end else begin
                addr_hit_s = addr_hit_s;
            end
        end
    end

    // Read issue: a free response slot must exist for every read not yet captured.
    always_comb begin
        credit_used_s = CU_W'(inflight_q) + CU_W'(rsp_count_s);
        credit_ok_s   = (credit_used_s < CU_W'(RSP_DEPTH));
        rd_ready      = live_q && credit_ok_s && !addr_hit_s;
        rd_fire_s     = rd_valid && rd_ready;
        ram_read      = rd_fire_s;
        if (rd_fire_s) begin
            ram_rd_address = rd_addr;
        end else begin
            ram_rd_address = '0;
        end
        inflight_d = rd_fire_s;
        live_d     = 1'b1;
        rsp_valid  = !rsp_empty_s;
        rsp_pop_s  = !rsp_empty_s && rsp_ready;
    end

    // Start-up gate and one-cycle read pipe marking RAM data to capture next edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            live_q     <= live_d;
            inflight_q <= inflight_d;
        end
    end

    ram_ctrl_fifo #(
        .T     (wr_req_t),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk           (clk),
        .resetn        (resetn),
        .push_i        (wfifo_push_s),
        .din_i         (wfifo_din_s),
        .pop_i         (wfifo_pop_s),
        .dout_o        (wfifo_head_s),
        .empty_o       (wfifo_empty_s),
        .full_o        (wfifo_full_s),
        .count_o       (wfifo_count),
        .entries_o     (wfifo_entries_s),
        .entry_valid_o (wfifo_valid_s)
    );

    // Response buffer: rsp_data comes straight from its registered head.
    ram_ctrl_fifo #(
        .T     (data_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .push_i        (inflight_q),
        .din_i         (ram_data_out),
        .pop_i         (rsp_pop_s),
        .dout_o        (rsp_data),
        .empty_o       (rsp_empty_s),
        .full_o        (rsp_full_unused_s),
        .count_o       (rsp_count_s),
        .entries_o     (rsp_entries_unused_s),
        .entry_valid_o (rsp_valid_unused_s)
    );

endmodule : ram_req_ctrl

// File: tb/tb_ram_req_ctrl.sv
`timescale 1ns/1ps
module tb_ram_req_ctrl;

    logic        clk;
    logic        resetn;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [11:0] rd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        ram_write;
    logic [11:0] ram_wr_address;
    logic [63:0] ram_data_in;
    logic        ram_read;
    logic [11:0] ram_rd_address;
    logic [63:0] ram_data_out;
    logic [2:0]  wfifo_count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] ram_mem [4096];
    logic [63:0] exp_mem [logic [11:0]];
    logic [63:0] exp_q [$];

    ram_req_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .ram_write      (ram_write),
        .ram_wr_address (ram_wr_address),
        .ram_data_in    (ram_data_in),
        .ram_read       (ram_read),
        .ram_rd_address (ram_rd_address),
        .ram_data_out   (ram_data_out),
        .wfifo_count    (wfifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram_4096 model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_wr_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= ram_mem[ram_rd_address];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected read data taken from what the bench wrote, checked in order.
    always @(negedge clk) begin
        if (resetn) begin
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("rsp_data_order", rsp_data, exp_q.pop_front());
            end
            if (rd_valid && rd_ready)
                exp_q.push_back(exp_mem.exists(rd_addr) ? exp_mem[rd_addr] : 64'h0);
            if (wr_valid && wr_ready) exp_mem[wr_addr] = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_wr_ready", wr_ready, 64'd1);
        check("rst_rd_ready", rd_ready, 64'd0);
        check("rst_rsp_valid", rsp_valid, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_ram_write", ram_write, 64'd0);
        check("rst_ram_read", ram_read, 64'd0);
        check("rst_wfifo_count", wfifo_count, 64'd0);
        check("rst_ram_wr_address", ram_wr_address, 64'd0);
        check("rst_ram_data_in", ram_data_in, 64'd0);
        check("rst_ram_rd_address", ram_rd_address, 64'd0);
    endtask

    task automatic wr_req(input logic [11:0] a, input logic [63:0] d);
        logic ok = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (wr_ready) begin ok = 1'b1; tick(); break; end
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", ok, 64'd1);
    endtask

    task automatic rd_req(input logic [11:0] a);
        logic ok = 1'b0;
        rd_valid = 1'b1; rd_addr = a;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rd_ready) begin ok = 1'b1; tick(); break; end
            tick();
        end
        rd_valid = 1'b0;
        check("rd_accept", ok, 64'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("rsp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; wr_addr = 12'h000; wr_data = 64'h0;
        rd_valid = 1'b0; rd_addr = 12'h000; rsp_ready = 1'b0;
        repeat (2) tick();
        #1;
        check_reset_values();

        // First cycle after release: no strobe even with a read pending.
        resetn = 1'b1; rd_valid = 1'b1; rd_addr = 12'h007;
        #1;
        check("first_cycle_ram_read", ram_read, 64'd0);
        check("first_cycle_rd_ready", rd_ready, 64'd0);
        rd_valid = 1'b0;
        tick();
        check("idle_rd_ready", rd_ready, 64'd1);
        check("idle_ram_write", ram_write, 64'd0);

        // Write then read the same address.
        wr_valid = 1'b1; wr_addr = 12'h005; wr_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        check("t1_wr_ready", wr_ready, 64'd1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 12'h005;
        #1;
        check("t1_count_one", wfifo_count, 64'd1);
        check("t1_ram_write", ram_write, 64'd1);
        check("t1_ram_wr_address", ram_wr_address, 64'h005);
        check("t1_ram_data_in", ram_data_in, 64'hDEAD_BEEF_0000_0001);
        check("t1_rd_blocked", rd_ready, 64'd0);
        check("t1_no_ram_read", ram_read, 64'd0);
        tick();
        check("t1_rd_ready", rd_ready, 64'd1);
        check("t1_ram_read", ram_read, 64'd1);
        check("t1_ram_rd_address", ram_rd_address, 64'h005);
        check("t1_count_zero", wfifo_count, 64'd0);
        tick();
        rd_valid = 1'b0;
        #1;
        check("t1_rsp_not_yet", rsp_valid, 64'd0);
        tick();
        check("t1_rsp_valid", rsp_valid, 64'd1);
        check("t1_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
        rsp_ready = 1'b1;
        tick();
        check("t1_rsp_popped", rsp_valid, 64'd0);

        // Six back-to-back writes with the drain running.
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = 12'(i); wr_data = 64'(i);
            #1;
            check("t2_wr_ready", wr_ready, 64'd1);
            if (i > 0) begin
                check("t2_count", wfifo_count, 64'd1);
                check("t2_ram_wr_address", ram_wr_address, 64'(i - 1));
                check("t2_ram_data_in", ram_data_in, 64'(i - 1));
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("t2_last_count", wfifo_count, 64'd1);
        check("t2_last_wr_address", ram_wr_address, 64'h005);
        tick();
        check("t2_empty", wfifo_count, 64'd0);
        for (int i = 0; i < 6; i++) rd_req(12'(i));
        wait_drain();

        // Response backpressure: third read waits for a free slot.
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 12'h000;
        #1;
        check("t3_rd0_ready", rd_ready, 64'd1);
        tick();
        rd_addr = 12'h001;
        #1;
        check("t3_rd1_ready", rd_ready, 64'd1);
        tick();
        rd_addr = 12'h002;
        #1;
        check("t3_rd2_blocked", rd_ready, 64'd0);
        tick();
        check("t3_rd2_still_blocked", rd_ready, 64'd0);
        check("t3_rsp_valid_held", rsp_valid, 64'd1);
        check("t3_rsp_head", rsp_data, 64'h0);
        tick();
        check("t3_rd2_blocked_late", rd_ready, 64'd0);
        check("t3_rsp_head_held", rsp_data, 64'h0);
        rsp_ready = 1'b1;
        rd_req(12'h002);
        wait_drain();

        // Concurrent RAM write and read to different addresses.
        wr_req(12'h200, 64'h55);
        repeat (2) tick();
        wr_valid = 1'b1; wr_addr = 12'h100; wr_data = 64'hAA;
        #1;
        check("t4_wr_ready", wr_ready, 64'd1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 12'h200;
        #1;
        check("t4_ram_write", ram_write, 64'd1);
        check("t4_ram_wr_address", ram_wr_address, 64'h100);
        check("t4_ram_read", ram_read, 64'd1);
        check("t4_ram_rd_address", ram_rd_address, 64'h200);
        tick();
        rd_valid = 1'b0;
        tick();
        check("t4_rsp_valid", rsp_valid, 64'd1);
        check("t4_rsp_data", rsp_data, 64'h55);
        tick();
        wait_drain();

        // Reset while writes are buffered and a read is in flight.
        rsp_ready = 1'b0;
        wr_valid = 1'b1; wr_addr = 12'h300; wr_data = 64'h1;
        rd_valid = 1'b1; rd_addr = 12'h100;
        #1;
        check("t5_rd_ready", rd_ready, 64'd1);
        tick();
        wr_addr = 12'h301; wr_data = 64'h2; rd_valid = 1'b0;
        #1;
        check("t5_count_before_reset", wfifo_count, 64'd1);
        resetn = 1'b0;
        #1;
        check_reset_values();
        wr_valid = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_rsp_valid", rsp_valid, 64'd0);
            check("t5_no_ram_write", ram_write, 64'd0);
        end
        rsp_ready = 1'b1;

        // Address extremes keep their own data.
        wr_req(12'hFFF, 64'h0123_4567_89AB_CDEF);
        wr_req(12'h000, 64'hFEDC_BA98_7654_3210);
        rd_req(12'hFFF);
        rd_req(12'h000);
        wait_drain();
        rd_req(12'hFFF);
        tick();
        check("t6_rsp_valid", rsp_valid, 64'd1);
        check("t6_rsp_data_fff", rsp_data, 64'h0123_4567_89AB_CDEF);
        tick();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ram_req_ctrl
